// File: rtl/conv_pkg.sv
// conv_pkg: shared types and helpers for the convolution batch sequencer.
//
// Contents:
//   conv_state_t  - sequencer state encoding (IDLE, CLEAR, ISSUE, DRAIN, WRITE, DONE)
//   MAX_LANES     - upper bound on the lane count supported by lane_mask_fn
//   nbatch()      - number of P-wide batches needed to cover SIZE outputs
//   lane_mask_fn()- per-lane "holds a real output" mask for a given batch base
package conv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } conv_state_t;

  localparam int MAX_LANES = 64;

  // ceil(size / p); usable in localparam expressions.
  function automatic int unsigned nbatch(input int unsigned size, input int unsigned p);
    return (size + p - 1) / p;
  endfunction

  // Bit i is set when lane i exists (i < lanes) and its output index
  // base + i is still inside the output vector. Callers truncate to P bits.
  function automatic logic [MAX_LANES-1:0] lane_mask_fn(input int unsigned base,
                                                        input int unsigned size,
                                                        input int unsigned lanes);
    logic [MAX_LANES-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      m[i] = (i < lanes) && ((base + i) < size);
    end
    return m;
  endfunction

endpackage

// File: rtl/conv_seq_addr_gen.sv
// conv_seq_addr_gen: combinational P-wide sample-address generator.
//
// Ports:
//   batch_base - output index of lane 0 in the current batch
//   k          - current filter tap
//   addr_x     - per-lane sample address, min(batch_base + i + k, LENX-1)
//
// Tail lanes past the end of the input vector are clamped to the last
// sample; their results are discarded by the lane mask downstream.
module conv_seq_addr_gen #(
  parameter int ADDRX   = 5,
  parameter int ADDRF   = 4,
  parameter int LENX    = 32,
  parameter int P       = 12,
  parameter int LOGSIZE = ADDRX
) (
  input  logic [LOGSIZE-1:0]         batch_base,
  input  logic [ADDRF-1:0]           k,
  output logic [P-1:0][ADDRX-1:0]    addr_x
);

  logic [31:0] sum;

  // Sum is formed at 32 bits so batch_base + i + k can never wrap before
  // the clamp comparison.
  always_comb begin
    addr_x = '0;
    sum    = '0;
    for (int i = 0; i < P; i++) begin
      sum = 32'(batch_base) + 32'(i) + 32'(k);
      if (sum > 32'(LENX - 1)) begin
        addr_x[i] = ADDRX'(LENX - 1);
      end else begin
        addr_x[i] = sum[ADDRX-1:0];
      end
    end
  end

endmodule

// File: rtl/conv_batch_sequencer.sv
// conv_batch_sequencer: walks the output vector in batches of P outputs,
// issuing per-lane sample addresses and filter tap addresses to a P-lane
// MAC bank, then hands each finished batch to the output buffer.
//
// Ports:
//   clk, reset    - clock, asynchronous active-high reset
//   start         - input buffer full (sampled only in IDLE)
//   op_ready      - output buffer can accept a batch
//   addr_x        - per-lane sample read address (0 when not issuing)
//   addr_f        - filter tap address (0 when not issuing)
//   rd_en         - address-issue strobe
//   clr_acc       - clear all lane accumulators
//   en_acc        - accumulate this cycle (rd_en delayed one cycle)
//   valid_op      - write the current batch to the output buffer
//   batch_base    - output index of lane 0 in the current batch
//   lane_mask     - bit i set when lane i holds a real output (0 when idle)
//   busy          - sequencer not idle
//   done          - one-cycle pulse at end of layer
//   x_release     - one-cycle pulse with done, frees the input buffer
//   stall_cycles  - saturating count of WRITE cycles with op_ready low
//
// Configuration:
//   CONV_SEQ_PERF_EN - when defined, stall_cycles is a live counter;
//                      otherwise it is tied to zero.
module conv_batch_sequencer
  import conv_pkg::*;
#(
  parameter int ADDRX   = 5,
  parameter int ADDRF   = 4,
  parameter int LENX    = 32,
  parameter int LENF    = 9,
  parameter int P       = 12,
  parameter int SIZE    = LENX - LENF + 1,
  parameter int LOGSIZE = ADDRX
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    op_ready,
  output logic [P-1:0][ADDRX-1:0] addr_x,
  output logic [ADDRF-1:0]        addr_f,
  output logic                    rd_en,
  output logic                    clr_acc,
  output logic                    en_acc,
  output logic                    valid_op,
  output logic [LOGSIZE-1:0]      batch_base,
  output logic [P-1:0]            lane_mask,
  output logic                    busy,
  output logic                    done,
  output logic                    x_release,
  output logic [15:0]             stall_cycles
);

  localparam int BW        = LOGSIZE + 1;
  localparam int NBATCH    = int'(nbatch(SIZE, P));
  localparam int LAST_BASE = (NBATCH - 1) * P;

  // Reject configurations the mask helper or the batch_base register
  // cannot represent.
  if (P > MAX_LANES || LAST_BASE > (2 ** LOGSIZE) - 1) begin : g_cfg_err
    $error("conv_batch_sequencer: unsupported P / LOGSIZE combination");
  end

  conv_state_t              state;
  logic [ADDRF-1:0]         k;
  logic [BW-1:0]            next_base;
  logic                     last_batch;
  logic [P-1:0][ADDRX-1:0]  gen_addr_x;

  // batch_base + P is formed one bit wider so it cannot wrap.
  assign next_base  = {1'b0, batch_base} + BW'(P);
  assign last_batch = (next_base >= BW'(SIZE));

  conv_seq_addr_gen #(
    .ADDRX   (ADDRX),
    .ADDRF   (ADDRF),
    .LENX    (LENX),
    .P       (P),
    .LOGSIZE (LOGSIZE)
  ) u_addr_gen (
    .batch_base (batch_base),
    .k          (k),
    .addr_x     (gen_addr_x)
  );

  // Addresses are only meaningful while issuing; elsewhere they read 0.
  assign addr_x    = rd_en ? gen_addr_x : '0;
  assign addr_f    = rd_en ? k : '0;
  assign valid_op  = (state == S_WRITE) && op_ready;
  assign lane_mask = busy ? P'(lane_mask_fn(32'(batch_base), SIZE, P)) : '0;

  // Strobes are registered together with the state transition so they
  // line up with the state they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      k          <= '0;
      batch_base <= '0;
      rd_en      <= 1'b0;
      clr_acc    <= 1'b0;
      en_acc     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      x_release  <= 1'b0;
    end else begin
      en_acc <= rd_en;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_CLEAR;
            batch_base <= '0;
            k          <= '0;
            clr_acc    <= 1'b1;
            busy       <= 1'b1;
          end
        end
        S_CLEAR: begin
          state   <= S_ISSUE;
          clr_acc <= 1'b0;
          rd_en   <= 1'b1;
          k       <= '0;
        end
        S_ISSUE: begin
          if (k == ADDRF'(LENF - 1)) begin
            state <= S_DRAIN;
            rd_en <= 1'b0;
          end else begin
            k <= k + 1'b1;
          end
        end
        S_DRAIN: begin
          state <= S_WRITE;
        end
        S_WRITE: begin
          if (op_ready) begin
            if (last_batch) begin
              state     <= S_DONE;
              done      <= 1'b1;
              x_release <= 1'b1;
            end else begin
              state      <= S_CLEAR;
              batch_base <= next_base[LOGSIZE-1:0];
              k          <= '0;
              clr_acc    <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state      <= S_IDLE;
          done       <= 1'b0;
          x_release  <= 1'b0;
          busy       <= 1'b0;
          batch_base <= '0;
          k          <= '0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef CONV_SEQ_PERF_EN
  logic [15:0] stall_q;

  // Counts back-pressure cycles for the layer; restarts with each accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (state == S_IDLE && start) begin
      stall_q <= '0;
    end else if (state == S_WRITE && !op_ready && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_conv_batch_sequencer.sv
// tb_conv_batch_sequencer: directed self-checking bench for
// conv_batch_sequencer. One instance uses default parameters, a second
// uses P=10 to exercise a three-batch layer with a partial last batch.
module tb_conv_batch_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Default-parameter instance (P=12, SIZE=24)
  logic              start, op_ready;
  logic [11:0][4:0]  addr_x;
  logic [3:0]        addr_f;
  logic              rd_en, clr_acc, en_acc, valid_op, busy, done, x_release;
  logic [4:0]        batch_base;
  logic [11:0]       lane_mask;
  logic [15:0]       stall_cycles;

  // P=10 instance
  logic              start_p10, op_ready_p10;
  logic [9:0][4:0]   addr_x_p10;
  logic [3:0]        addr_f_p10;
  logic              rd_en_p10, clr_acc_p10, en_acc_p10, valid_op_p10;
  logic              busy_p10, done_p10, x_release_p10;
  logic [4:0]        batch_base_p10;
  logic [9:0]        lane_mask_p10;
  logic [15:0]       stall_cycles_p10;

  conv_batch_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .op_ready     (op_ready),
    .addr_x       (addr_x),
    .addr_f       (addr_f),
    .rd_en        (rd_en),
    .clr_acc      (clr_acc),
    .en_acc       (en_acc),
    .valid_op     (valid_op),
    .batch_base   (batch_base),
    .lane_mask    (lane_mask),
    .busy         (busy),
    .done         (done),
    .x_release    (x_release),
    .stall_cycles (stall_cycles)
  );

  conv_batch_sequencer #(.P(10)) dut_p10 (
    .clk          (clk),
    .reset        (reset),
    .start        (start_p10),
    .op_ready     (op_ready_p10),
    .addr_x       (addr_x_p10),
    .addr_f       (addr_f_p10),
    .rd_en        (rd_en_p10),
    .clr_acc      (clr_acc_p10),
    .en_acc       (en_acc_p10),
    .valid_op     (valid_op_p10),
    .batch_base   (batch_base_p10),
    .lane_mask    (lane_mask_p10),
    .busy         (busy_p10),
    .done         (done_p10),
    .x_release    (x_release_p10),
    .stall_cycles (stall_cycles_p10)
  );

  int checks   = 0;
  int failures = 0;
  int n_valid;
  int n_done;
  int cyc;
  logic exp_clr, exp_rd, exp_en, exp_valid, exp_done, exp_busy;
  logic [15:0] exp_stall;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic r);
    start    = s;
    op_ready = r;
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, " addr_x"},       64'(addr_x),       64'd0);
    checkOutput({tag, " addr_f"},       64'(addr_f),       64'd0);
    checkOutput({tag, " rd_en"},        64'(rd_en),        64'd0);
    checkOutput({tag, " clr_acc"},      64'(clr_acc),      64'd0);
    checkOutput({tag, " en_acc"},       64'(en_acc),       64'd0);
    checkOutput({tag, " valid_op"},     64'(valid_op),     64'd0);
    checkOutput({tag, " batch_base"},   64'(batch_base),   64'd0);
    checkOutput({tag, " lane_mask"},    64'(lane_mask),    64'd0);
    checkOutput({tag, " busy"},         64'(busy),         64'd0);
    checkOutput({tag, " done"},         64'(done),         64'd0);
    checkOutput({tag, " x_release"},    64'(x_release),    64'd0);
    checkOutput({tag, " stall_cycles"}, 64'(stall_cycles), 64'd0);
  endtask

  initial begin
    // ---- Reset state ----
    reset        = 1'b1;
    applyStimulus(1'b0, 1'b1);
    start_p10    = 1'b0;
    op_ready_p10 = 1'b1;
    tick();
    tick();
    checkIdleZero("reset");
    checkOutput("reset busy_p10", 64'(busy_p10), 64'd0);
    reset = 1'b0;

    // ---- Nominal layer, with start pulses during ISSUE and DONE ----
    applyStimulus(1'b1, 1'b1);
    tick();
    n_valid = 0;
    n_done  = 0;
    for (int c = 1; c <= 27; c++) begin
      exp_clr   = (c == 1) || (c == 13);
      exp_rd    = (c >= 2 && c <= 10) || (c >= 14 && c <= 22);
      exp_en    = (c >= 3 && c <= 11) || (c >= 15 && c <= 23);
      exp_valid = (c == 12) || (c == 24);
      exp_done  = (c == 25);
      exp_busy  = (c <= 25);
      checkOutput($sformatf("clr_acc c%0d", c),   64'(clr_acc),   64'(exp_clr));
      checkOutput($sformatf("rd_en c%0d", c),     64'(rd_en),     64'(exp_rd));
      checkOutput($sformatf("en_acc c%0d", c),    64'(en_acc),    64'(exp_en));
      checkOutput($sformatf("valid_op c%0d", c),  64'(valid_op),  64'(exp_valid));
      checkOutput($sformatf("done c%0d", c),      64'(done),      64'(exp_done));
      checkOutput($sformatf("x_release c%0d", c), 64'(x_release), 64'(exp_done));
      checkOutput($sformatf("busy c%0d", c),      64'(busy),      64'(exp_busy));
      if (valid_op) n_valid++;
      if (done) n_done++;
      if (c == 2) begin
        checkOutput("b1 k0 addr_f",     64'(addr_f),     64'd0);
        checkOutput("b1 k0 addr_x[0]",  64'(addr_x[0]),  64'd0);
        checkOutput("b1 k0 addr_x[11]", 64'(addr_x[11]), 64'd11);
      end
      if (c == 12) begin
        checkOutput("b1 batch_base", 64'(batch_base), 64'd0);
        checkOutput("b1 lane_mask",  64'(lane_mask),  64'hFFF);
      end
      if (c == 17) begin
        checkOutput("b2 k3 addr_f",     64'(addr_f),     64'd3);
        checkOutput("b2 k3 addr_x[0]",  64'(addr_x[0]),  64'd15);
        checkOutput("b2 k3 addr_x[11]", 64'(addr_x[11]), 64'd26);
      end
      if (c == 24) begin
        checkOutput("b2 batch_base", 64'(batch_base), 64'd12);
        checkOutput("b2 lane_mask",  64'(lane_mask),  64'hFFF);
      end
      start = (c == 5) || (c == 25);
      tick();
    end
    checkOutput("nominal valid_op count", 64'(n_valid), 64'd2);
    checkOutput("nominal done count",     64'(n_done),  64'd1);

    // ---- Output back-pressure: op_ready low for 5 cycles in first WRITE ----
    applyStimulus(1'b1, 1'b0);
    tick();
    start = 1'b0;
    repeat (11) tick();
    for (int s = 0; s < 5; s++) begin
      checkOutput($sformatf("stall%0d valid_op", s), 64'(valid_op), 64'd0);
      checkOutput($sformatf("stall%0d rd_en", s),    64'(rd_en),    64'd0);
      checkOutput($sformatf("stall%0d en_acc", s),   64'(en_acc),   64'd0);
      checkOutput($sformatf("stall%0d clr_acc", s),  64'(clr_acc),  64'd0);
      checkOutput($sformatf("stall%0d lane_mask", s), 64'(lane_mask), 64'hFFF);
      tick();
    end
    op_ready = 1'b1;
    #1;
    checkOutput("stall release valid_op", 64'(valid_op), 64'd1);
`ifdef CONV_SEQ_PERF_EN
    exp_stall = 16'd5;
`else
    exp_stall = 16'd0;
`endif
    checkOutput("stall_cycles", 64'(stall_cycles), 64'(exp_stall));
    tick();
    checkOutput("post-stall clr_acc",    64'(clr_acc),    64'd1);
    checkOutput("post-stall batch_base", 64'(batch_base), 64'd12);
    repeat (4) tick();
    checkOutput("b2 mid-issue rd_en",  64'(rd_en),  64'd1);
    checkOutput("b2 mid-issue addr_f", 64'(addr_f), 64'd3);

    // ---- Asynchronous reset mid-ISSUE of batch 2 ----
    reset = 1'b1;
    #1;
    checkIdleZero("mid-issue reset");
    tick();
    reset = 1'b0;
    n_valid = 0;
    for (int c = 0; c < 15; c++) begin
      if (valid_op || busy) n_valid++;
      tick();
    end
    checkOutput("no activity after reset", 64'(n_valid), 64'd0);

    // ---- Replay from batch_base 0 ----
    applyStimulus(1'b1, 1'b1);
    tick();
    start = 1'b0;
    checkOutput("replay c1 clr_acc",    64'(clr_acc),    64'd1);
    checkOutput("replay c1 rd_en",      64'(rd_en),      64'd0);
    checkOutput("replay c1 batch_base", 64'(batch_base), 64'd0);
    checkOutput("replay c1 lane_mask",  64'(lane_mask),  64'hFFF);
    tick();
    checkOutput("replay c2 rd_en",     64'(rd_en),     64'd1);
    checkOutput("replay c2 en_acc",    64'(en_acc),    64'd0);
    checkOutput("replay c2 addr_x[0]", 64'(addr_x[0]), 64'd0);
    tick();
    checkOutput("replay c3 en_acc", 64'(en_acc), 64'd1);
    cyc = 3;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
    end
    checkOutput("replay done cycle", 64'(cyc), 64'd25);
    tick();
    checkOutput("replay busy after done", 64'(busy), 64'd0);

    // ---- P=10: three batches, partial last batch with clamped addresses ----
    start_p10 = 1'b1;
    tick();
    start_p10 = 1'b0;
    n_valid = 0;
    for (int c = 1; c <= 38; c++) begin
      if (valid_op_p10) n_valid++;
      if (c == 12) begin
        checkOutput("p10 b1 valid_op",  64'(valid_op_p10),  64'd1);
        checkOutput("p10 b1 lane_mask", 64'(lane_mask_p10), 64'h3FF);
      end
      if (c == 24) begin
        checkOutput("p10 b2 batch_base", 64'(batch_base_p10), 64'd10);
      end
      if (c == 34) begin
        checkOutput("p10 b3 k8 rd_en",     64'(rd_en_p10),      64'd1);
        checkOutput("p10 b3 k8 addr_f",    64'(addr_f_p10),     64'd8);
        checkOutput("p10 b3 k8 addr_x[0]", 64'(addr_x_p10[0]), 64'd28);
        checkOutput("p10 b3 k8 addr_x[3]", 64'(addr_x_p10[3]), 64'd31);
        checkOutput("p10 b3 k8 addr_x[9]", 64'(addr_x_p10[9]), 64'd31);
      end
      if (c == 36) begin
        checkOutput("p10 b3 valid_op",   64'(valid_op_p10),   64'd1);
        checkOutput("p10 b3 batch_base", 64'(batch_base_p10), 64'd20);
        checkOutput("p10 b3 lane_mask",  64'(lane_mask_p10),  64'h00F);
      end
      if (c == 37) begin
        checkOutput("p10 done",      64'(done_p10),      64'd1);
        checkOutput("p10 x_release", 64'(x_release_p10), 64'd1);
      end
      tick();
    end
    checkOutput("p10 valid_op count", 64'(n_valid), 64'd3);
    checkOutput("p10 busy at end",    64'(busy_p10), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_batch_sequencer.md
# conv_batch_sequencer

Sequencer for the P-lane convolution datapath: one P-lane multiply-accumulate bank, a P-port input-sample buffer and a filter ROM. Once the input buffer is loaded, the sequencer walks the output vector in batches of P outputs. For each batch it generates per-lane sample addresses and the filter tap address, plus the accumulator clear/enable strobes. It then hands each finished batch to the output buffer under a ready handshake, and releases the input buffer when the last batch is written.

## Interface
Parameters:
- ADDRX, 5, sample-address width
- ADDRF, 4, filter-address width
- LENX, 32, input vector length
- LENF, 9, filter length
- P, 12, number of MAC lanes
- SIZE, LENX-LENF+1, output vector length
- LOGSIZE, ADDRX, output-address width

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  input buffer full; sampled only in IDLE
- op_ready  in  1  output buffer can accept a batch
- addr_x  out  [P-1:0][ADDRX-1:0]  per-lane sample read address
- addr_f  out  ADDRF  filter tap address
- rd_en  out  1  address-issue strobe
- clr_acc  out  1  clear all lane accumulators
- en_acc  out  1  accumulate this cycle (rd_en delayed 1 cycle)
- valid_op  out  1  write the current batch to the output buffer
- batch_base  out  LOGSIZE  output index of lane 0 in the current batch
- lane_mask  out  P  bit i = lane i holds a real output
- busy  out  1  not IDLE
- done  out  1  one-cycle pulse at end of layer
- x_release  out  1  one-cycle pulse, coincident with done, freeing the input buffer
- stall_cycles  out  16  saturating count of WRITE cycles with op_ready=0

## Operation
- States and transitions:
  - IDLE: start=1 → CLEAR, batch_base=0.
  - CLEAR: one cycle, clr_acc=1, tap k=0 → ISSUE.
  - ISSUE: LENF cycles, rd_en=1, k increments. After k=LENF-1 → DRAIN.
  - DRAIN: one cycle. Only en_acc is high, for the final tap. → WRITE.
  - WRITE: valid_op = op_ready. The state is held while op_ready=0.
    - On the handshake, if batch_base+P ≥ SIZE → DONE.
    - Otherwise batch_base += P → CLEAR.
  - DONE: one cycle, done=x_release=1 → IDLE.
- Address rules:
  - addr_f = k.
  - addr_x[i] = min(batch_base+i+k, LENX-1). Tail lanes are clamped and their results are masked.
- Mask and timing rules:
  - lane_mask[i] = (batch_base+i < SIZE). It is valid whenever busy and is held through WRITE.
  - en_acc is rd_en registered once, which matches the 1-cycle registered read of the buffer and ROM.
- Stall and edge cases:
  - While stalled in WRITE, rd_en, en_acc and clr_acc are 0 and the accumulators hold.
  - start outside IDLE is ignored. This includes start during DONE.
  - Reset at any time forces IDLE and sets every output and counter to 0 immediately. No partial batch is written.
- Number of batches = ceil(SIZE/P). Arithmetic on batch_base and k is unsigned, at LOGSIZE+1 bits to avoid wrap on batch_base+P.

## Timing
- Reset values: all outputs 0.
- start sampled high at edge 0 → CLEAR is visible in cycle 1.
- Per batch, with op_ready=1: LENF+3 cycles (CLEAR + LENF ISSUE + DRAIN + WRITE).
- Layer latency from start to done = ceil(SIZE/P)·(LENF+3)+1 cycles.
- done and x_release are single-cycle pulses. busy is low in the cycle after DONE.

## Configuration
- CONV_SEQ_PERF_EN defined:
  - stall_cycles counts cycles in WRITE with op_ready=0, saturating at 16'hFFFF.
  - It is cleared on reset and on start accepted in IDLE.
- CONV_SEQ_PERF_EN undefined: the stall_cycles port remains and is tied to 0, with no counter logic.

## Structure
- Shared package conv_pkg holds:
  - the state enum (IDLE, CLEAR, ISSUE, DRAIN, WRITE, DONE);
  - localparam function nbatch(SIZE,P);
  - the lane-mask helper function.
- Sub-module conv_seq_addr_gen: a purely combinational, P-wide clamped address generator taking batch_base and k.

## Test plan
- Defaults, op_ready=1, start at cycle 0 → expected waveform:
  - clr_acc in cycle 1, rd_en in cycles 2–10, en_acc in cycles 3–11.
  - valid_op in cycle 12 with batch_base=0, lane_mask=12'hFFF.
  - Second batch: valid_op in cycle 24 with batch_base=12.
  - done=x_release in cycle 25.
- Defaults, batch 2, tap k=3 → addr_f=3, addr_x[0]=15, addr_x[11]=26.
- P=10 (SIZE=24) → three batches.
  - Third batch: batch_base=20, lane_mask=10'h00F.
  - At k=8: addr_x[9]=31 (clamped from 37), addr_x[3]=31.
- op_ready held 0 for 5 cycles in the first WRITE:
  - valid_op stays 0; rd_en, en_acc and clr_acc stay 0.
  - valid_op asserts in the cycle op_ready returns.
  - With CONV_SEQ_PERF_EN, stall_cycles=5; without it, stall_cycles=0.
- Reset asserted mid-ISSUE of batch 2:
  - All outputs are 0 in the same cycle, and no valid_op follows.
  - A new start replays from batch_base=0 with the cycle-1 timing above.
- start pulsed during ISSUE and during DONE → ignored, so exactly two valid_op and one done are seen.
